// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue: pipeline write requests, drain strobe,
// register-file write port and the two forwarding lookups.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_valid_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_ready_o;
    logic          drain_en_i;
    logic          regwrite_o;
    logic [AW-1:0] writeaddr_o;
    logic [DW-1:0] writedata_o;
    logic [AW-1:0] rsaddr_i;
    logic [AW-1:0] rtaddr_i;
    logic          rs_hit_o;
    logic          rt_hit_o;
    logic [DW-1:0] rs_data_o;
    logic [DW-1:0] rt_data_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, drain_en_i, rsaddr_i, rtaddr_i,
        output wr_ready_o, regwrite_o, writeaddr_o, writedata_o,
               rs_hit_o, rt_hit_o, rs_data_o, rt_data_o, count_o
    );

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, drain_en_i, rsaddr_i, rtaddr_i,
        input  wr_ready_o, regwrite_o, writeaddr_o, writedata_o,
               rs_hit_o, rt_hit_o, rs_data_o, rt_data_o, count_o
    );
endinterface

// File: rtl/wb_write_queue.sv
// FIFO of pending register writes draining one per enabled cycle into the
// register file, with newest-value forwarding on two lookup addresses.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    wb_write_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          regwrite_reg;
    logic [AW-1:0] waddr_reg;
    logic [DW-1:0] wdata_reg;

    logic full, enq, deq;

    // Refusal when full holds even if a drain frees a slot this same edge.
    assign full = (count_reg == CW'(DEPTH));
    assign enq  = bus.wr_valid_i && !full && (bus.wr_addr_i != '0);
    assign deq  = bus.drain_en_i && (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage is unreset; entry validity comes from head/count alone.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_mem[tail_reg] <= bus.wr_addr_i;
            data_mem[tail_reg] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            regwrite_reg <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            count_reg    <= count_next;
            regwrite_reg <= deq;
            if (enq) tail_reg <= tail_reg + 1'b1;
            if (deq) begin
                head_reg  <= head_reg + 1'b1;
                waddr_reg <= addr_mem[head_reg];
                wdata_reg <= data_mem[head_reg];
            end
        end
    end

    assign bus.wr_ready_o  = !full;
    assign bus.count_o     = count_reg;
    assign bus.regwrite_o  = regwrite_reg;
    assign bus.writeaddr_o = waddr_reg;
    assign bus.writedata_o = wdata_reg;

    logic [AW-1:0] lk_addr [2];
    logic          lk_hit  [2];
    logic [DW-1:0] lk_data [2];

    assign lk_addr[0]    = bus.rsaddr_i;
    assign lk_addr[1]    = bus.rtaddr_i;
    assign bus.rs_hit_o  = lk_hit[0];
    assign bus.rs_data_o = lk_data[0];
    assign bus.rt_hit_o  = lk_hit[1];
    assign bus.rt_data_o = lk_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
            logic [PW-1:0] idx;
            // Scan lowest priority first so later (newer) matches override.
            always_comb begin
                lk_hit[gi]  = 1'b0;
                lk_data[gi] = '0;
                idx         = head_reg;
                if (lk_addr[gi] != '0) begin
                    if (regwrite_reg && (waddr_reg == lk_addr[gi])) begin
                        lk_hit[gi]  = 1'b1;
                        lk_data[gi] = wdata_reg;
                    end
                    for (int k = 0; k < DEPTH; k++) begin
                        idx = head_reg + PW'(k);
                        if ((CW'(k) < count_reg) && (addr_mem[idx] == lk_addr[gi])) begin
                            lk_hit[gi]  = 1'b1;
                            lk_data[gi] = data_mem[idx];
                        end
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized + directed bench for wb_write_queue against a queue-based model
// of pending writes and the register-file output register.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    wb_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    ent_t          mq[$];
    logic          m_rw;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic [AW-1:0] drained[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rw = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    task automatic lookup(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == a) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                    return;
                end
            end
            if (m_rw && m_wa == a) begin
                hit = 1'b1;
                d   = m_wd;
            end
        end
    endtask

    task automatic check_all();
        logic h;
        logic [DW-1:0] d;
        chk("count", 64'(bus.count_o), 64'(mq.size()));
        chk("wr_ready", 64'(bus.wr_ready_o), 64'(mq.size() < DEPTH));
        chk("regwrite", 64'(bus.regwrite_o), 64'(m_rw));
        chk("writeaddr", 64'(bus.writeaddr_o), 64'(m_wa));
        chk("writedata", 64'(bus.writedata_o), 64'(m_wd));
        lookup(bus.rsaddr_i, h, d);
        chk("rs_hit", 64'(bus.rs_hit_o), 64'(h));
        chk("rs_data", 64'(bus.rs_data_o), 64'(d));
        lookup(bus.rtaddr_i, h, d);
        chk("rt_hit", 64'(bus.rt_hit_o), 64'(h));
        chk("rt_data", 64'(bus.rt_data_o), 64'(d));
    endtask

    // Entered and left at a falling edge; outputs sampled 1ns after inputs settle.
    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic de, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        logic acc, drn;
        ent_t e;
        bus.wr_valid_i = v;
        bus.wr_addr_i  = a;
        bus.wr_data_i  = d;
        bus.drain_en_i = de;
        bus.rsaddr_i   = rs;
        bus.rtaddr_i   = rt;
        #1;
        check_all();
        acc = v && (mq.size() < DEPTH) && (a != 0);
        drn = de && (mq.size() > 0);
        @(posedge clk_i);
        if (drn) begin
            e    = mq.pop_front();
            m_rw = 1'b1;
            m_wa = e.a;
            m_wd = e.d;
            drained.push_back(e.a);
        end else begin
            m_rw = 1'b0;
        end
        if (acc) mq.push_back('{a: a, d: d});
        @(negedge clk_i);
    endtask

    initial begin
        bus.wr_valid_i = 1'b0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.drain_en_i = 1'b0;
        bus.rsaddr_i   = '0;
        bus.rtaddr_i   = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_ready", 64'(bus.wr_ready_o), 64'd1);
        chk("rst_regwrite", 64'(bus.regwrite_o), 64'd0);
        rst_n_i = 1'b1;

        // Single write / forward / drain
        cyc(1, 5, 32'hA5A5A5A5, 0, 5, 0);
        chk("single_count", 64'(bus.count_o), 64'd1);
        chk("single_fwd", 64'(bus.rs_data_o), 64'hA5A5A5A5);
        cyc(0, 0, 0, 1, 5, 0);
        chk("single_rw", 64'(bus.regwrite_o), 64'd1);
        chk("single_wa", 64'(bus.writeaddr_o), 64'd5);
        chk("single_wd", 64'(bus.writedata_o), 64'hA5A5A5A5);
        chk("single_hit_in_rw", 64'(bus.rs_hit_o), 64'd1);
        cyc(0, 0, 0, 1, 5, 0);
        chk("single_rw_off", 64'(bus.regwrite_o), 64'd0);
        chk("single_hit_off", 64'(bus.rs_hit_o), 64'd0);

        // Full: fifth request refused, never drained
        for (int i = 1; i <= 4; i++) cyc(1, AW'(i), DW'(i), 0, 6, 0);
        chk("full_ready", 64'(bus.wr_ready_o), 64'd0);
        chk("full_count", 64'(bus.count_o), 64'd4);
        cyc(1, 6, 32'h66, 0, 6, 0);
        chk("full_refused_hit", 64'(bus.rs_hit_o), 64'd0);
        drained.delete();
        repeat (6) cyc(0, 0, 0, 1, 6, 0);
        chk("full_drain_n", 64'(drained.size()), 64'd4);
        foreach (drained[i]) chk("full_drain_ord", 64'(drained[i]), 64'(i + 1));

        // Same-address ordering
        cyc(1, 7, 32'h1, 0, 0, 7);
        cyc(1, 7, 32'h2, 0, 0, 7);
        chk("same_fwd_newest", 64'(bus.rt_data_o), 64'h2);
        cyc(0, 0, 0, 1, 0, 7);
        chk("same_first", 64'(bus.writedata_o), 64'h1);
        cyc(0, 0, 0, 1, 0, 7);
        chk("same_second", 64'(bus.writedata_o), 64'h2);
        cyc(0, 0, 0, 1, 0, 7);

        // Register 0 dropped
        cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        chk("r0_count", 64'(bus.count_o), 64'd0);
        chk("r0_hit", 64'(bus.rs_hit_o), 64'd0);
        chk("r0_data", 64'(bus.rs_data_o), 64'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("r0_no_rw", 64'(bus.regwrite_o), 64'd0);

        // Wrap and concurrency
        drained.delete();
        for (int i = 1; i <= 10; i++) begin
            cyc(1, AW'(i), DW'(i * 32'h11), 1, AW'(i), 0);
            chk("wrap_count_le1", 64'(bus.count_o <= 1), 64'd1);
        end
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        chk("wrap_n", 64'(drained.size()), 64'd10);
        foreach (drained[i]) chk("wrap_ord", 64'(drained[i]), 64'(i + 1));

        // Reset mid-operation
        for (int i = 1; i <= 4; i++) cyc(1, AW'(i + 8), DW'(i), 0, 0, 0);
        cyc(0, 0, 0, 1, 9, 0);
        chk("mid_pre_rw", 64'(bus.regwrite_o), 64'd1);
        chk("mid_pre_count", 64'(bus.count_o), 64'd3);
        #2 rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("mid_count", 64'(bus.count_o), 64'd0);
        chk("mid_rw", 64'(bus.regwrite_o), 64'd0);
        chk("mid_wa", 64'(bus.writeaddr_o), 64'd0);
        chk("mid_wd", 64'(bus.writedata_o), 64'd0);
        chk("mid_ready", 64'(bus.wr_ready_o), 64'd1);
        chk("mid_hit", 64'(bus.rs_hit_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) cyc(0, 0, 0, 1, 9, 10);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), DW'($urandom),
                ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        repeat (6) cyc(0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
